// File: rtl/hub75_bcm.sv
// Bit-code-modulation sequencer for a HUB75 panel: shifts each bit plane LSB first,
// latches it and lights it for T_BASE<<plane clocks, overlapping the next shift.
module hub75_bcm #(
    parameter int N_ROWS   = 32,
    parameter int N_PLANES = 8,
    parameter int T_BASE   = 16,
    localparam int LOG_N_ROWS   = $clog2(N_ROWS),
    localparam int LOG_N_PLANES = $clog2(N_PLANES),
    localparam int TW           = $clog2(T_BASE) + N_PLANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LOG_N_ROWS-1:0]   ctrl_row,
    input  logic                    ctrl_go,
    output logic                    ctrl_rdy,
    output logic [LOG_N_PLANES-1:0] shift_plane,
    output logic                    shift_go,
    input  logic                    shift_rdy,
    output logic [LOG_N_ROWS-1:0]   phy_addr,
    output logic                    phy_le,
    output logic                    phy_blank
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_UNBLANK = 3'd4;

    localparam logic [LOG_N_PLANES-1:0] LAST_PLANE =
        LOG_N_PLANES'(N_PLANES - 1);

    logic [2:0]              state_q, state_d;
    logic [LOG_N_PLANES-1:0] plane_q, plane_d;
    logic [LOG_N_ROWS-1:0]   row_q,   row_d;
    logic [LOG_N_ROWS-1:0]   addr_q,  addr_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    blank_q, blank_d;

    always_comb begin
        state_d = state_q;
        plane_d = plane_q;
        row_d   = row_q;
        addr_d  = addr_q;
        timer_d = timer_q;
        blank_d = blank_q;

        // Lit-time timer runs regardless of state so shifting overlaps it
        if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
            if (timer_q == TW'(1)) begin
                blank_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (ctrl_go && shift_rdy) begin
                    row_d   = ctrl_row;
                    plane_d = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (shift_rdy && timer_q == '0) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                addr_d  = row_q;
                state_d = S_UNBLANK;
            end
            S_UNBLANK: begin
                timer_d = TW'(T_BASE) << plane_q;
                blank_d = 1'b0;
                if (plane_q == LAST_PLANE) begin
                    state_d = S_IDLE;
                end else begin
                    plane_d = plane_q + 1'b1;
                    state_d = S_SHIFT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            plane_q <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            timer_q <= '0;
            blank_q <= 1'b1;
        end else begin
            state_q <= state_d;
            plane_q <= plane_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            timer_q <= timer_d;
            blank_q <= blank_d;
        end
    end

    assign ctrl_rdy    = (state_q == S_IDLE) && shift_rdy;
    assign shift_go    = (state_q == S_SHIFT);
    assign shift_plane = plane_q;
    assign phy_le      = (state_q == S_LATCH);
    assign phy_addr    = addr_q;
    assign phy_blank   = blank_q;

endmodule

// File: tb/tb_hub75_bcm.sv
// Scoreboard bench for hub75_bcm: a shifter model stays busy K cycles per shift_go,
// a monitor records panel events and each test task compares them to pushed expectations.
module tb_hub75_bcm;

    localparam int NR = 4;
    localparam int NP = 4;
    localparam int TB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ctrl_row = '0;
    logic       ctrl_go = 1'b0;
    logic       ctrl_rdy;
    logic [1:0] shift_plane;
    logic       shift_go;
    logic       shift_rdy = 1'b1;
    logic [1:0] phy_addr;
    logic       phy_le;
    logic       phy_blank;

    hub75_bcm #(.N_ROWS(NR), .N_PLANES(NP), .T_BASE(TB)) dut (
        .clk(clk), .rst(rst),
        .ctrl_row(ctrl_row), .ctrl_go(ctrl_go), .ctrl_rdy(ctrl_rdy),
        .shift_plane(shift_plane), .shift_go(shift_go), .shift_rdy(shift_rdy),
        .phy_addr(phy_addr), .phy_le(phy_le), .phy_blank(phy_blank)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Shifter model: shift_rdy low for K cycles starting with the shift_go cycle
    int K = 3;
    int busy = 0;
    bit hold = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) busy = 0;
        else if (shift_go) busy = K;
        else if (busy > 0) busy--;
        shift_rdy = (busy == 0) && !hold;
    end

    // Monitor
    int cyc = 0;
    bit prev_blank = 1'b1;
    int win_len = 0;
    int win_addr = 0;
    int last_rise = 0;
    int lit_viol = 0;
    int le_cnt = 0;
    int obs_plane[$], obs_len[$], obs_waddr[$], obs_gap[$], obs_rdy[$];
    int obs_le_addr[$], obs_go_cyc[$], obs_le_cyc[$], obs_fall_cyc[$];
    int exp_plane[$], exp_len[$], exp_addr[$];
    int go_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (shift_go) begin
                obs_plane.push_back(int'(shift_plane));
                obs_go_cyc.push_back(cyc);
            end
            if (phy_le) begin
                le_cnt++;
                obs_le_addr.push_back(int'(phy_addr));
                obs_le_cyc.push_back(cyc);
            end
            if (!phy_blank) begin
                if (prev_blank) begin
                    win_len = 1;
                    win_addr = int'(phy_addr);
                    obs_gap.push_back(cyc - last_rise);
                    obs_rdy.push_back(int'(ctrl_rdy));
                    obs_fall_cyc.push_back(cyc);
                end else begin
                    win_len++;
                    if (int'(phy_addr) != win_addr) lit_viol++;
                end
                if (phy_le) lit_viol++;
            end else if (!prev_blank) begin
                obs_len.push_back(win_len);
                obs_waddr.push_back(win_addr);
                last_rise = cyc;
            end
        end
        prev_blank = phy_blank;
    end

    task automatic clr();
        obs_plane.delete(); obs_len.delete(); obs_waddr.delete();
        obs_gap.delete(); obs_rdy.delete(); obs_le_addr.delete();
        obs_go_cyc.delete(); obs_le_cyc.delete(); obs_fall_cyc.delete();
        exp_plane.delete(); exp_len.delete(); exp_addr.delete();
        le_cnt = 0;
        lit_viol = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic issue_go(input int row);
        int n = 0;
        tick(1);
        while (!ctrl_rdy && n < 500) begin
            tick(1);
            n++;
        end
        if (!ctrl_rdy) begin
            total++; bad++;
            $display("FAIL issue_go_rdy got=0 want=1 (timeout)");
        end
        ctrl_row = 2'(row);
        ctrl_go = 1'b1;
        go_cyc = cyc;
        for (int p = 0; p < NP; p++) begin
            exp_plane.push_back(p);
            exp_len.push_back(TB << p);
            exp_addr.push_back(row);
        end
        tick(1);
        ctrl_go = 1'b0;
    endtask

    task automatic wait_wins(input int n);
        int b = 0;
        while (obs_len.size() < n && b < 3000) begin
            tick(1);
            b++;
        end
        if (obs_len.size() < n) begin
            total++; bad++;
            $display("FAIL wait_wins got=%0d want=%0d (timeout)", obs_len.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hold = 1'b0;
        tick(3);
        total++; if (phy_blank !== 1'b1) begin bad++; $display("FAIL rst_blank got=%b want=1", phy_blank); end
        total++; if (phy_le !== 1'b0) begin bad++; $display("FAIL rst_le got=%b want=0", phy_le); end
        total++; if (phy_addr !== 2'd0) begin bad++; $display("FAIL rst_addr got=%0d want=0", phy_addr); end
        total++; if (ctrl_rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy got=%b want=1", ctrl_rdy); end
        total++; if (shift_go !== 1'b0) begin bad++; $display("FAIL rst_go got=%b want=0", shift_go); end
        rst = 1'b0;
        tick(2);
        total++; if (phy_blank !== 1'b1) begin bad++; $display("FAIL post_rst_blank got=%b want=1", phy_blank); end
        total++; if (ctrl_rdy !== 1'b1) begin bad++; $display("FAIL post_rst_rdy got=%b want=1", ctrl_rdy); end
    endtask

    task automatic test_latency();
        clr();
        K = 1;
        issue_go(1);
        wait_wins(4);
        total++; if (obs_go_cyc.size() < 1 || obs_go_cyc[0] != go_cyc + 1) begin
            bad++; $display("FAIL lat_go got=%0d want=%0d", obs_go_cyc.size() ? obs_go_cyc[0] - go_cyc : -1, 1); end
        total++; if (obs_le_cyc.size() < 1 || obs_le_cyc[0] != go_cyc + 3) begin
            bad++; $display("FAIL lat_le got=%0d want=%0d", obs_le_cyc.size() ? obs_le_cyc[0] - go_cyc : -1, 3); end
        total++; if (obs_fall_cyc.size() < 1 || obs_fall_cyc[0] != go_cyc + 5) begin
            bad++; $display("FAIL lat_blank got=%0d want=%0d", obs_fall_cyc.size() ? obs_fall_cyc[0] - go_cyc : -1, 5); end
        total++; if (obs_plane.size() != NP) begin
            bad++; $display("FAIL lat_go_count got=%0d want=%0d", obs_plane.size(), NP); end
    endtask

    task automatic test_basic();
        int want;
        clr();
        K = 3;
        issue_go(2);
        wait_wins(4);
        total++; if (obs_plane.size() != 4 || obs_len.size() != 4) begin
            bad++; $display("FAIL basic_count got=%0d/%0d want=4/4", obs_plane.size(), obs_len.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (obs_plane[i] != exp_plane[i]) begin bad++;
                    $display("FAIL basic_plane[%0d] got=%0d want=%0d", i, obs_plane[i], exp_plane[i]); end
                total++; if (obs_len[i] != exp_len[i]) begin bad++;
                    $display("FAIL basic_len[%0d] got=%0d want=%0d", i, obs_len[i], exp_len[i]); end
                total++; if (obs_waddr[i] != exp_addr[i]) begin bad++;
                    $display("FAIL basic_addr[%0d] got=%0d want=%0d", i, obs_waddr[i], exp_addr[i]); end
                want = (i == 3) ? 1 : 0;
                total++; if (obs_rdy[i] != want) begin bad++;
                    $display("FAIL basic_rdy[%0d] got=%0d want=%0d", i, obs_rdy[i], want); end
                if (i > 0) begin
                    want = ((K > exp_len[i-1]) ? K : exp_len[i-1]) + 3 - exp_len[i-1];
                    total++; if (obs_gap[i] != want) begin bad++;
                        $display("FAIL basic_gap[%0d] got=%0d want=%0d", i, obs_gap[i], want); end
                end
            end
        end
        total++; if (le_cnt != 4) begin bad++; $display("FAIL basic_le got=%0d want=4", le_cnt); end
        total++; if (lit_viol != 0) begin bad++; $display("FAIL basic_lit got=%0d want=0", lit_viol); end
    endtask

    task automatic test_slow();
        int want;
        clr();
        K = 50;
        issue_go(0);
        wait_wins(4);
        total++; if (obs_len.size() != 4 || obs_gap.size() != 4) begin
            bad++; $display("FAIL slow_count got=%0d want=4", obs_len.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++; if (obs_len[i] != exp_len[i]) begin bad++;
                    $display("FAIL slow_len[%0d] got=%0d want=%0d", i, obs_len[i], exp_len[i]); end
                if (i > 0) begin
                    want = ((K > exp_len[i-1]) ? K : exp_len[i-1]) + 3 - exp_len[i-1];
                    total++; if (obs_gap[i] != want) begin bad++;
                        $display("FAIL slow_gap[%0d] got=%0d want=%0d", i, obs_gap[i], want); end
                end
            end
        end
        total++; if (le_cnt != 4) begin bad++; $display("FAIL slow_le got=%0d want=4", le_cnt); end
        total++; if (obs_plane.size() != 4) begin bad++; $display("FAIL slow_go got=%0d want=4", obs_plane.size()); end
        K = 3;
    endtask

    task automatic test_overlap();
        clr();
        K = 3;
        issue_go(2);
        issue_go(3);
        wait_wins(8);
        total++; if (obs_len.size() != 8 || obs_le_addr.size() != 8) begin
            bad++; $display("FAIL ovl_count got=%0d want=8", obs_len.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++; if (obs_len[i] != exp_len[i] || obs_waddr[i] != exp_addr[i]) begin bad++;
                    $display("FAIL ovl_win[%0d] got=%0d@%0d want=%0d@%0d", i, obs_len[i], obs_waddr[i], exp_len[i], exp_addr[i]); end
            end
            total++; if (obs_le_addr[4] != 2) begin bad++;
                $display("FAIL ovl_le_addr got=%0d want=2", obs_le_addr[4]); end
            total++; if (obs_gap[4] != 3) begin bad++;
                $display("FAIL ovl_gap got=%0d want=3", obs_gap[4]); end
            total++; if (obs_le_cyc[4] <= obs_fall_cyc[3] + 31) begin bad++;
                $display("FAIL ovl_le_early got=%0d want>%0d", obs_le_cyc[4], obs_fall_cyc[3] + 31); end
        end
        total++; if (le_cnt != 8) begin bad++; $display("FAIL ovl_le got=%0d want=8", le_cnt); end
        total++; if (lit_viol != 0) begin bad++; $display("FAIL ovl_lit got=%0d want=0", lit_viol); end
    endtask

    task automatic test_ignore();
        clr();
        K = 3;
        issue_go(1);
        ctrl_row = 2'd0;
        ctrl_go = 1'b1;
        tick(3);
        ctrl_go = 1'b0;
        wait_wins(4);
        hold = 1'b1;
        tick(2);
        total++; if (ctrl_rdy !== 1'b0) begin bad++; $display("FAIL ign_rdy got=%b want=0", ctrl_rdy); end
        ctrl_go = 1'b1;
        tick(5);
        ctrl_go = 1'b0;
        tick(5);
        total++; if (obs_plane.size() != 4) begin bad++; $display("FAIL ign_go got=%0d want=4", obs_plane.size()); end
        total++; if (le_cnt != 4) begin bad++; $display("FAIL ign_le got=%0d want=4", le_cnt); end
        total++; if (obs_waddr.size() != 4 || obs_waddr[3] != 1) begin bad++;
            $display("FAIL ign_addr got=%0d want=1", obs_waddr.size() ? obs_waddr[obs_waddr.size()-1] : -1); end
        hold = 1'b0;
        tick(2);
    endtask

    task automatic test_midreset();
        int b = 0;
        clr();
        K = 3;
        issue_go(1);
        wait_wins(2);
        while (phy_blank && b < 200) begin tick(1); b++; end
        tick(8);
        total++; if (phy_blank !== 1'b0) begin bad++; $display("FAIL mid_lit got=%b want=0", phy_blank); end
        rst = 1'b1;
        tick(1);
        total++; if (phy_blank !== 1'b1) begin bad++; $display("FAIL mid_blank got=%b want=1", phy_blank); end
        total++; if (phy_le !== 1'b0) begin bad++; $display("FAIL mid_le got=%b want=0", phy_le); end
        total++; if (phy_addr !== 2'd0) begin bad++; $display("FAIL mid_addr got=%0d want=0", phy_addr); end
        total++; if (shift_go !== 1'b0) begin bad++; $display("FAIL mid_go got=%b want=0", shift_go); end
        total++; if (ctrl_rdy !== 1'b1) begin bad++; $display("FAIL mid_rdy got=%b want=1", ctrl_rdy); end
        rst = 1'b0;
        tick(20);
        total++; if (obs_fall_cyc.size() != 3) begin bad++;
            $display("FAIL mid_dark got=%0d want=3", obs_fall_cyc.size()); end
        total++; if (ctrl_rdy !== 1'b1) begin bad++; $display("FAIL mid_rdy2 got=%b want=1", ctrl_rdy); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_basic();
        test_slow();
        test_overlap();
        test_ignore();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
